// File: rtl/led_sout_capture.sv
// Readback receiver for TLC5955 daisy chains: samples each chain's SOUT on SCLK
// rising edges, deserializes device segments and streams 16-bit words to a buffer.
module ledSoutLane (
  input  logic        spiClk,
  input  logic        nReset,
  input  logic        shiftEn,
  input  logic        sin,
  output logic [15:0] nextWord
);
  logic [15:0] sr;

  assign nextWord = {sr[14:0], sin};

  always_ff @(posedge spiClk) begin
    if (!nReset)      sr <= '0;
    else if (shiftEn) sr <= nextWord;
  end
endmodule

module led_sout_capture #(
  parameter int NUM_SHIFT    = 8,
  parameter int NUM_TLC5955  = 2,
  parameter int BITS_PER_DEV = 769,
  localparam int WORDS  = NUM_TLC5955 * 48,
  localparam int ADDR_W = $clog2(WORDS)
) (
  input  logic                   spiClk,
  input  logic                   nReset,
  input  logic                   enable,
  input  logic                   SCLK,
  input  logic                   LAT,
  input  logic [NUM_SHIFT-1:0]   SOUT,
  output logic                   wrEn,
  output logic [ADDR_W-1:0]      wrAddress,
  output logic [NUM_SHIFT*16-1:0] wrData,
  output logic                   frameDone,
  output logic                   frameErr,
  output logic [NUM_TLC5955-1:0] selBits,
  output logic [15:0]            frameCount,
  output logic                   busy
);
  localparam int SEG_W = (NUM_TLC5955 > 1) ? $clog2(NUM_TLC5955) : 1;
  localparam logic [11:0] FRAME_BITS = 12'(NUM_TLC5955 * BITS_PER_DEV);
  localparam logic [11:0] SAT_BITS   = FRAME_BITS + 12'd1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEL  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] FULL = 2'd3;

  logic [1:0]              state;
  logic                    sclkD, latD;
  logic                    sclkRise, latRise, dataShift;
  logic [11:0]             bitCount, bitCountInc;
  logic [ADDR_W-1:0]       wordCnt;
  logic [9:0]              segBit;
  logic [SEG_W-1:0]        segIdx;
  logic [NUM_TLC5955-1:0]  selShadow;
  logic [NUM_SHIFT*16-1:0] laneNext;

  assign sclkRise    = SCLK && !sclkD;
  assign latRise     = LAT && !latD;
  assign dataShift   = enable && (state == DATA) && sclkRise && !latRise;
  assign bitCountInc = (bitCount == SAT_BITS) ? bitCount : bitCount + 12'd1;
  assign busy        = (state == SEL) || (state == DATA);

  for (genvar i = 0; i < NUM_SHIFT; i++) begin : gLane
    ledSoutLane uLane (
      .spiClk   (spiClk),
      .nReset   (nReset),
      .shiftEn  (dataShift),
      .sin      (SOUT[i]),
      .nextWord (laneNext[16*i +: 16])
    );
  end

  always_ff @(posedge spiClk) begin
    if (!nReset) begin
      state      <= IDLE;
      sclkD      <= 1'b0;
      latD       <= 1'b0;
      bitCount   <= '0;
      wordCnt    <= '0;
      segBit     <= '0;
      segIdx     <= '0;
      selShadow  <= '0;
      wrEn       <= 1'b0;
      wrAddress  <= '0;
      wrData     <= '0;
      frameDone  <= 1'b0;
      frameErr   <= 1'b0;
      selBits    <= '0;
      frameCount <= '0;
    end else begin
      sclkD     <= SCLK;
      latD      <= LAT;
      wrEn      <= 1'b0;
      frameDone <= 1'b0;
      frameErr  <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        bitCount <= '0;
        wordCnt  <= '0;
        segBit   <= '0;
        segIdx   <= '0;
      end else if (latRise) begin
        if (state != IDLE) begin
          if (bitCount == FRAME_BITS) begin
            frameDone  <= 1'b1;
            selBits    <= selShadow;
            frameCount <= frameCount + 16'd1;
          end else begin
            frameErr <= 1'b1;
          end
        end
        wordCnt <= '0;
        segBit  <= '0;
        segIdx  <= '0;
        // A coincident SCLK edge becomes the select bit of the new frame.
        if (sclkRise && state != IDLE) begin
          selShadow[0] <= SOUT[0];
          bitCount     <= 12'd1;
          state        <= DATA;
        end else begin
          bitCount <= '0;
          state    <= SEL;
        end
      end else if (sclkRise) begin
        case (state)
          SEL: begin
            selShadow[segIdx] <= SOUT[0];
            bitCount          <= bitCountInc;
            state             <= DATA;
          end
          DATA: begin
            bitCount <= bitCountInc;
            if (segBit[3:0] == 4'hF) begin
              wrEn      <= 1'b1;
              wrData    <= laneNext;
              wrAddress <= wordCnt;
              wordCnt   <= wordCnt + 1'b1;
            end
            if (segBit == 10'd767) begin
              segBit <= '0;
              if (segIdx == SEG_W'(NUM_TLC5955 - 1)) begin
                state <= FULL;
              end else begin
                segIdx <= segIdx + 1'b1;
                state  <= SEL;
              end
            end else begin
              segBit <= segBit + 10'd1;
            end
          end
          FULL: bitCount <= bitCountInc;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_led_sout_capture.sv
// Directed bench for led_sout_capture: two lanes, two devices per chain.
module tb_led_sout_capture;
  localparam int NS = 2;
  localparam int ND = 2;

  logic          spiClk = 1'b0;
  logic          nReset, enable, SCLK, LAT;
  logic [NS-1:0] SOUT;
  logic          wrEn, frameDone, frameErr, busy;
  logic [6:0]    wrAddress;
  logic [31:0]   wrData;
  logic [ND-1:0] selBits;
  logic [15:0]   frameCount;

  int checks = 0;
  int failures = 0;
  int wrCnt = 0;
  int doneCnt = 0;
  int errCnt = 0;
  logic [6:0]  addrLog [0:1023];
  logic [31:0] dataLog [0:1023];

  led_sout_capture #(.NUM_SHIFT(NS), .NUM_TLC5955(ND), .BITS_PER_DEV(769)) dut (
    .spiClk(spiClk), .nReset(nReset), .enable(enable), .SCLK(SCLK), .LAT(LAT),
    .SOUT(SOUT), .wrEn(wrEn), .wrAddress(wrAddress), .wrData(wrData),
    .frameDone(frameDone), .frameErr(frameErr), .selBits(selBits),
    .frameCount(frameCount), .busy(busy)
  );

  always #5 spiClk = ~spiClk;

  always @(negedge spiClk) begin
    if (wrEn === 1'b1) begin
      if (wrCnt < 1024) begin
        addrLog[wrCnt] <= wrAddress;
        dataLog[wrCnt] <= wrData;
      end
      wrCnt <= wrCnt + 1;
    end
    if (frameDone === 1'b1) doneCnt <= doneCnt + 1;
    if (frameErr === 1'b1)  errCnt  <= errCnt + 1;
  end

  // Lane-0 stream: per segment, select bit then words seg*48+1.. MSB-first.
  function automatic logic bitOf(int i, logic sel1);
    int seg, r, j;
    logic [15:0] w;
    if (i >= 1538) return 1'b0;
    seg = i / 769;
    r   = i % 769;
    if (r == 0) return (seg == 1) ? sel1 : 1'b0;
    j = r - 1;
    w = 16'(seg * 48 + j / 16 + 1);
    return w[15 - j % 16];
  endfunction

  function automatic int badWrites(int base);
    int bad = 0;
    logic [15:0] w;
    for (int k = 0; k < 96; k++) begin
      w = 16'(k + 1);
      if (addrLog[base + k] !== 7'(k) || dataLog[base + k] !== {~w, w}) bad++;
    end
    return bad;
  endfunction

  task automatic idle(int n);
    repeat (n) @(negedge spiClk);
    #1;
  endtask

  task automatic sendBits(int from, int to, logic sel1);
    logic b;
    for (int i = from; i < to; i++) begin
      @(negedge spiClk);
      b = bitOf(i, sel1);
      SOUT = {~b, b};
      SCLK = 1'b1;
      @(negedge spiClk);
      SCLK = 1'b0;
    end
  endtask

  task automatic pulseLat();
    @(negedge spiClk);
    LAT = 1'b1;
    @(negedge spiClk);
    LAT = 1'b0;
  endtask

  task automatic test_reset();
    nReset = 1'b0; enable = 1'b0; SCLK = 1'b0; LAT = 1'b0; SOUT = '0;
    idle(3);
    checks++; if (wrEn !== 1'b0) begin failures++; $display("FAIL reset_wrEn got=%b exp=0", wrEn); end
    checks++; if (wrAddress !== 7'd0 || wrData !== 32'd0) begin failures++; $display("FAIL reset_wr got=%h/%h exp=0/0", wrAddress, wrData); end
    checks++; if (frameDone !== 1'b0 || frameErr !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", frameDone, frameErr); end
    checks++; if (selBits !== 2'b00 || frameCount !== 16'd0 || busy !== 1'b0) begin failures++; $display("FAIL reset_status got=%b/%0d/%b exp=00/0/0", selBits, frameCount, busy); end
    nReset = 1'b1; enable = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    int base = wrCnt, d0 = doneCnt, e0 = errCnt, bad;
    pulseLat();
    idle(1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL good_busy got=%b exp=1", busy); end
    sendBits(0, 1538, 1'b0);
    pulseLat();
    idle(3);
    checks++; if (wrCnt - base !== 96) begin failures++; $display("FAIL good_wrcount got=%0d exp=96", wrCnt - base); end
    bad = badWrites(base);
    checks++; if (bad !== 0) begin failures++; $display("FAIL good_wrdata bad_entries=%0d exp=0", bad); end
    checks++; if (doneCnt - d0 !== 1 || errCnt - e0 !== 0) begin failures++; $display("FAIL good_pulses done=%0d err=%0d exp=1/0", doneCnt - d0, errCnt - e0); end
    checks++; if (frameCount !== 16'd1 || selBits !== 2'b00) begin failures++; $display("FAIL good_status cnt=%0d sel=%b exp=1/00", frameCount, selBits); end
  endtask

  task automatic test_select_bit();
    int base = wrCnt, d0 = doneCnt, bad;
    sendBits(0, 1538, 1'b1);
    pulseLat();
    idle(3);
    bad = badWrites(base);
    checks++; if (wrCnt - base !== 96 || bad !== 0) begin failures++; $display("FAIL sel_writes count=%0d bad=%0d exp=96/0", wrCnt - base, bad); end
    checks++; if (doneCnt - d0 !== 1 || selBits !== 2'b10 || frameCount !== 16'd2) begin failures++; $display("FAIL sel_status done=%0d sel=%b cnt=%0d exp=1/10/2", doneCnt - d0, selBits, frameCount); end
  endtask

  task automatic test_short_frame();
    int base = wrCnt, d0 = doneCnt, e0 = errCnt, bad;
    sendBits(0, 1000, 1'b0);
    pulseLat();
    idle(3);
    checks++; if (wrCnt - base !== 62) begin failures++; $display("FAIL short_wrcount got=%0d exp=62", wrCnt - base); end
    checks++; if (errCnt - e0 !== 1 || doneCnt - d0 !== 0) begin failures++; $display("FAIL short_pulses err=%0d done=%0d exp=1/0", errCnt - e0, doneCnt - d0); end
    checks++; if (frameCount !== 16'd2 || selBits !== 2'b10) begin failures++; $display("FAIL short_status cnt=%0d sel=%b exp=2/10", frameCount, selBits); end
    base = wrCnt;
    sendBits(0, 1538, 1'b0);
    pulseLat();
    idle(3);
    bad = badWrites(base);
    checks++; if (wrCnt - base !== 96 || bad !== 0) begin failures++; $display("FAIL short_next_writes count=%0d bad=%0d exp=96/0", wrCnt - base, bad); end
    checks++; if (doneCnt - d0 !== 1 || frameCount !== 16'd3 || selBits !== 2'b00) begin failures++; $display("FAIL short_next_status done=%0d cnt=%0d sel=%b exp=1/3/00", doneCnt - d0, frameCount, selBits); end
  endtask

  task automatic test_overrun();
    int base = wrCnt, d0 = doneCnt, e0 = errCnt, mid;
    sendBits(0, 1538, 1'b0);
    idle(2);
    mid = wrCnt;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL overrun_busy got=%b exp=0", busy); end
    sendBits(1538, 1540, 1'b0);
    idle(2);
    checks++; if (mid - base !== 96 || wrCnt !== mid) begin failures++; $display("FAIL overrun_writes at1538=%0d extra=%0d exp=96/0", mid - base, wrCnt - mid); end
    pulseLat();
    idle(3);
    checks++; if (errCnt - e0 !== 1 || doneCnt - d0 !== 0 || frameCount !== 16'd3) begin failures++; $display("FAIL overrun_pulses err=%0d done=%0d cnt=%0d exp=1/0/3", errCnt - e0, doneCnt - d0, frameCount); end
  endtask

  task automatic test_back_to_back();
    int base = wrCnt, d0 = doneCnt, e0 = errCnt, bad;
    sendBits(0, 1538, 1'b0);
    @(negedge spiClk);
    SOUT = {~bitOf(0, 1'b0), bitOf(0, 1'b0)};
    SCLK = 1'b1;
    LAT  = 1'b1;
    @(negedge spiClk);
    SCLK = 1'b0;
    LAT  = 1'b0;
    idle(2);
    checks++; if (doneCnt - d0 !== 1 || frameCount !== 16'd4) begin failures++; $display("FAIL b2b_first done=%0d cnt=%0d exp=1/4", doneCnt - d0, frameCount); end
    sendBits(1, 1538, 1'b0);
    pulseLat();
    idle(3);
    checks++; if (doneCnt - d0 !== 2 || errCnt - e0 !== 0 || frameCount !== 16'd5) begin failures++; $display("FAIL b2b_second done=%0d err=%0d cnt=%0d exp=2/0/5", doneCnt - d0, errCnt - e0, frameCount); end
    bad = badWrites(base) + badWrites(base + 96);
    checks++; if (wrCnt - base !== 192 || bad !== 0) begin failures++; $display("FAIL b2b_writes count=%0d bad=%0d exp=192/0", wrCnt - base, bad); end
  endtask

  task automatic test_enable();
    int base, d0 = doneCnt, e0 = errCnt, bad;
    sendBits(0, 500, 1'b0);
    @(negedge spiClk);
    enable = 1'b0;
    idle(2);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL en_busy got=%b exp=0", busy); end
    enable = 1'b1;
    base = wrCnt;
    sendBits(0, 200, 1'b0);
    idle(2);
    checks++; if (wrCnt !== base) begin failures++; $display("FAIL en_idle_writes got=%0d exp=0", wrCnt - base); end
    pulseLat();
    sendBits(0, 16, 1'b0);
    @(negedge spiClk);
    SOUT = {~bitOf(16, 1'b0), bitOf(16, 1'b0)};
    SCLK = 1'b1;
    enable = 1'b0;
    @(negedge spiClk);
    SCLK = 1'b0;
    enable = 1'b1;
    idle(3);
    checks++; if (wrCnt !== base) begin failures++; $display("FAIL en_pending_write got=%0d exp=0", wrCnt - base); end
    pulseLat();
    sendBits(0, 1538, 1'b0);
    pulseLat();
    idle(3);
    bad = badWrites(base);
    checks++; if (wrCnt - base !== 96 || bad !== 0) begin failures++; $display("FAIL en_writes count=%0d bad=%0d exp=96/0", wrCnt - base, bad); end
    checks++; if (doneCnt - d0 !== 1 || frameCount !== 16'd6 || errCnt - e0 !== 0) begin failures++; $display("FAIL en_status done=%0d cnt=%0d err=%0d exp=1/6/0", doneCnt - d0, frameCount, errCnt - e0); end
  endtask

  task automatic test_reset_mid();
    int e0 = errCnt;
    sendBits(0, 800, 1'b0);
    @(negedge spiClk);
    nReset = 1'b0;
    idle(1);
    checks++; if (frameCount !== 16'd0 || selBits !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_status cnt=%0d sel=%b busy=%b exp=0/00/0", frameCount, selBits, busy); end
    checks++; if (wrEn !== 1'b0 || wrAddress !== 7'd0 || wrData !== 32'd0 || frameDone !== 1'b0 || frameErr !== 1'b0) begin failures++; $display("FAIL rstmid_outputs wr=%b/%h/%h done=%b err=%b exp=all0", wrEn, wrAddress, wrData, frameDone, frameErr); end
    nReset = 1'b1;
    idle(4);
    checks++; if (errCnt !== e0) begin failures++; $display("FAIL rstmid_err got=%0d exp=0", errCnt - e0); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_select_bit();
    test_short_frame();
    test_overrun();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
